dlx_inst_encoder: RTL and testbench
===================================

Name: dlx_inst_encoder

Overview:
Encoder counterpart to the DLX instruction decoder. Accepts decoded instruction fields on a valid/ready request interface and emits 32-bit DLX instruction words on a valid/ready output interface. Expands the load-immediate pseudo-op (LI) into one or two real words: ADDI, or LHI optionally followed by ORI. Sits between the test/boot program generator and instruction memory or the fetch stage.

Parameters:
COUNT_W, 16, width of the emitted-word counter (used only with DLX_ENC_COUNT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_valid  input  1  request fields valid
req_ready  output  1  request accepted this cycle when req_valid && req_ready
req_li  input  1  request is LI pseudo-op; opcode/func/rs fields ignored
req_opcode  input  6  DLX opcode, becomes inst[31:26]
req_func  input  6  R-type function code, becomes inst[5:0]
req_rd  input  5  destination register (store source register for stores)
req_rs1  input  5  source 1 / base register
req_rs2  input  5  source 2 register (R-type only)
req_imm  input  32  immediate, jump offset, or LI constant
inst_valid  output  1  inst holds a valid word
inst_ready  input  1  downstream accepts inst when inst_valid && inst_ready
inst  output  32  encoded instruction word
inst_count  output  COUNT_W  emitted-word count (DLX_ENC_COUNT_EN only)

Behaviour:
- One clock domain (clk); reset asynchronous, active-high. Reset values: inst_valid=0, inst=0, FSM=IDLE, inst_count=0. req_ready is combinational and is therefore 1 during reset.
- Format selection on req_opcode:
  - R-type for opcodes 0x00 and 0x01: {opcode, rs1[25:21], rs2[20:16], rd[15:11], 5'b0, func}.
  - J-type for opcodes 0x02 and 0x03: {opcode, req_imm[25:0]}.
  - I-type for all other opcodes: {opcode, rs1[25:21], rd[20:16], req_imm[15:0]}.
  - Upper immediate bits are silently truncated.
- LI expansion (rd=req_rd, constant K=req_imm):
  - If K[31:15] is all 0s or all 1s, emit one word: ADDI rd,r0,K[15:0] (opcode 0x08).
  - Otherwise, word 1 is LHI rd,K[31:16] (opcode 0x0f, rs1=0).
  - Word 2, ORI rd,rd,K[15:0] (opcode 0x0d, rs1=rd), is emitted only if K[15:0]!=0.
- Output register: a single stage. The slot is free when !inst_valid || inst_ready.
- FSM states:
  - IDLE: req_ready = slot free. On accept, load the first word into inst and set inst_valid=1. If an ORI is still pending, capture rd and K[15:0] and move to SECOND; otherwise stay in IDLE.
  - SECOND: req_ready=0. When the slot is free, load the ORI word, keep inst_valid=1, and return to IDLE.
- Latency: a word is visible one cycle after acceptance. Sustained throughput is 1 word/cycle with inst_ready held high; a two-word LI costs one request-bubble cycle.
- Simultaneous handshake: if the output handshake and a new load occur in the same cycle, inst is replaced and inst_valid stays 1. If the output handshake occurs with no new load, inst_valid drops to 0 and inst holds its last value.
- Backpressure: inst and inst_valid stay stable while inst_valid && !inst_ready.
- Reset mid-operation (including in SECOND) drops the pending ORI and returns to IDLE with inst_valid=0.

Optional Feature:
DLX_ENC_COUNT_EN:
- When defined, inst_count increments by 1 on every output handshake (inst_valid && inst_ready), wraps modulo 2^COUNT_W, and resets to 0.
- When undefined, the inst_count port and its counter are absent.

Test Plan:
- ADD r3,r1,r2 (opcode 0x00, func 0x20, rs1=1, rs2=2, rd=3), inst_ready=1 -> next cycle inst=0x00221820, inst_valid=1.
- LI r5,0x12345678 -> inst=0x3C051234 then inst=0x34A55678 on consecutive cycles; req_ready=0 during the SECOND cycle.
- LI r4,0xFFFFFFF0 -> single word 0x2004FFF0. LI r6,0x00010000 -> single word 0x3C060001 with no ORI.
- J with imm=0x100 -> 0x08000100. SW with opcode 0x2b, rs1=2, rd=7, imm=8 -> 0xAC470008.
- Backpressure: hold inst_ready=0 for 3 cycles with LI r5,0x12345678 pending -> inst=0x3C051234 stable and req_ready=0 throughout. Release -> 0x34A55678 follows; with the count feature enabled, inst_count=2 afterwards.
- Assert reset while in SECOND -> inst_valid=0 immediately, no ORI ever emitted, req_ready=1 on release.

Source files
------------

// File: rtl/dlx_inst_encoder.sv
// dlx_inst_encoder: turns decoded DLX instruction fields into 32-bit words.
// The LI pseudo-op becomes either ADDI, or LHI optionally followed by ORI.
// A single registered output stage sits on a valid/ready interface.
// Optional feature macro: DLX_ENC_COUNT_EN adds the inst_count output, which
// counts output handshakes.
module dlx_inst_encoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_func,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst
`ifdef DLX_ENC_COUNT_EN
  ,
  output logic [COUNT_W-1:0] inst_count
`endif
);

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LHI  = 6'h0f;
  localparam logic [5:0] OP_ORI  = 6'h0d;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [15:0] pend_lo_q, pend_lo_d;

  logic        slot_free;
  logic        accept;
  logic        out_fire;
  logic [31:0] first_word;
  logic        needs_ori;

  // Encode the first (or only) word of the current request.
  always_comb begin
    first_word = '0;
    needs_ori  = 1'b0;
    if (req_li) begin
      if ((&req_imm[31:15]) || !(|req_imm[31:15])) begin
        first_word = {OP_ADDI, 5'd0, req_rd, req_imm[15:0]};
      end else begin
        first_word = {OP_LHI, 5'd0, req_rd, req_imm[31:16]};
        needs_ori  = |req_imm[15:0];
      end
    end else begin
      case (req_opcode)
        6'h00, 6'h01: first_word = {req_opcode, req_rs1, req_rs2, req_rd, 5'd0, req_func};
        6'h02, 6'h03: first_word = {req_opcode, req_imm[25:0]};
        default:      first_word = {req_opcode, req_rs1, req_rd, req_imm[15:0]};
      endcase
    end
  end

  // Handshake qualifiers for both interfaces.
  always_comb begin
    slot_free = !inst_valid_q || inst_ready;
    req_ready = (state_q == IDLE) && slot_free;
    accept    = req_valid && req_ready;
    out_fire  = inst_valid_q && inst_ready;
  end

  // Next-state logic: the output slot is drained by out_fire and refilled by a
  // new load in the same cycle, so a load overrides the drop of inst_valid.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_lo_d    = pend_lo_q;
    if (out_fire) begin
      inst_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          inst_d       = first_word;
          inst_valid_d = 1'b1;
          if (req_li && needs_ori) begin
            pend_rd_d = req_rd;
            pend_lo_d = req_imm[15:0];
            state_d   = SECOND;
          end
        end
      end
      SECOND: begin
        if (slot_free) begin
          inst_d       = {OP_ORI, pend_rd_q, pend_rd_q, pend_lo_q};
          inst_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register; reset drops any pending ORI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_lo_q    <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_lo_q    <= pend_lo_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

`ifdef DLX_ENC_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  // Emitted-word counter, wraps naturally at 2^COUNT_W.
  always_comb begin
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign inst_count = count_q;
`endif

endmodule

// File: tb/tb_dlx_inst_encoder.sv
// Bench for dlx_inst_encoder: directed vectors plus randomized traffic checked
// against a queue-based model of the words the encoder should emit.
module tb_dlx_inst_encoder;

  localparam int unsigned COUNT_W = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_li;
  logic [5:0]  req_opcode;
  logic [5:0]  req_func;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
`ifdef DLX_ENC_COUNT_EN
  logic [COUNT_W-1:0] inst_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] exp_q[$];
  int unsigned model_count = 0;

  dlx_inst_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_li     (req_li),
    .req_opcode (req_opcode),
    .req_func   (req_func),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst)
`ifdef DLX_ENC_COUNT_EN
    ,
    .inst_count (inst_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the words a request should produce, from the format rules.
  task automatic push_expected(input logic li, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    int signed   k;
    int unsigned hi, lo;
    k  = $signed(imm);
    hi = imm >> 16;
    lo = imm % 65536;
    if (li) begin
      if (k >= -32768 && k <= 32767)
        exp_q.push_back((32'd8 << 26) | (32'(rd) << 16) | lo);
      else begin
        exp_q.push_back((32'd15 << 26) | (32'(rd) << 16) | hi);
        if (lo != 0)
          exp_q.push_back((32'd13 << 26) | (32'(rd) << 21) | (32'(rd) << 16) | lo);
      end
    end else if (op < 2)
      exp_q.push_back((32'(op) << 26) | (32'(rs1) << 21) | (32'(rs2) << 16) | (32'(rd) << 11) | 32'(fn));
    else if (op < 4)
      exp_q.push_back((32'(op) << 26) | (imm % (32'd1 << 26)));
    else
      exp_q.push_back((32'(op) << 26) | (32'(rs1) << 21) | (32'(rd) << 16) | lo);
  endtask

  // Per-cycle scoreboard; inputs only change in the first half of the cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_count = 0;
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      chk("mon_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
      chk("mon_ready", {31'd0, req_ready},
          {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && inst_ready)});
`ifdef DLX_ENC_COUNT_EN
      chk("mon_count", 32'(inst_count), model_count % (32'd1 << COUNT_W));
`endif
      if (inst_valid && inst_ready) begin
        if (exp_q.size() != 0) chk("mon_word", inst, exp_q.pop_front());
        model_count++;
      end
      if (req_valid && req_ready)
        push_expected(req_li, req_opcode, req_func, req_rd, req_rs1, req_rs2, req_imm);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input logic li, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int unsigned n;
    req_li = li; req_opcode = op; req_func = fn; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("accept_in_time", {31'd0, n < 20}, 32'd1);
    cyc();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_li = 1'b0; req_opcode = '0; req_func = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; inst_ready = 1'b1;
    #2;
    chk("reset_inst", inst, 32'd0);
    chk("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    cyc();
    cyc();
    reset = 1'b0;
    #1;

    send(1'b0, 6'h00, 6'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_word", inst, 32'h00221820);
    chk("add_valid", {31'd0, inst_valid}, 32'd1);
    cyc();

    send(1'b1, 6'h00, 6'h00, 5'd5, 5'd0, 5'd0, 32'h12345678);
    chk("li_lhi", inst, 32'h3C051234);
    chk("li_ready_second", {31'd0, req_ready}, 32'd0);
    cyc();
    chk("li_ori", inst, 32'h34A55678);
    chk("li_ori_valid", {31'd0, inst_valid}, 32'd1);
    cyc();
    chk("li_drained", {31'd0, inst_valid}, 32'd0);

    send(1'b1, 6'h00, 6'h00, 5'd4, 5'd0, 5'd0, 32'hFFFFFFF0);
    chk("li_addi", inst, 32'h2004FFF0);
    cyc();
    chk("li_addi_single", {31'd0, inst_valid}, 32'd0);

    send(1'b1, 6'h00, 6'h00, 5'd6, 5'd0, 5'd0, 32'h00010000);
    chk("li_lhi_only", inst, 32'h3C060001);
    cyc();
    chk("li_no_ori", {31'd0, inst_valid}, 32'd0);

    send(1'b1, 6'h00, 6'h00, 5'd4, 5'd0, 5'd0, 32'hFFFF8000);
    chk("li_addi_neg_edge", inst, 32'h20048000);
    cyc();

    send(1'b0, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'h00000100);
    chk("j_word", inst, 32'h08000100);
    send(1'b0, 6'h2b, 6'h00, 5'd7, 5'd2, 5'd0, 32'd8);
    chk("sw_word", inst, 32'hAC470008);
    cyc();

    // Backpressure across a two-word LI, from a fresh count.
    do_reset();
    inst_ready = 1'b0;
    send(1'b1, 6'h00, 6'h00, 5'd5, 5'd0, 5'd0, 32'h12345678);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("bp_word", inst, 32'h3C051234);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      cyc();
    end
    inst_ready = 1'b1;
    cyc();
    chk("bp_ori", inst, 32'h34A55678);
    cyc();
    chk("bp_drained", {31'd0, inst_valid}, 32'd0);
`ifdef DLX_ENC_COUNT_EN
    chk("bp_count", 32'(inst_count), 32'd2);
`endif

    // Reset while the ORI is still pending.
    send(1'b1, 6'h00, 6'h00, 5'd5, 5'd0, 5'd0, 32'h12345678);
    reset = 1'b1;
    #1;
    chk("rs2_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rs2_ready", {31'd0, req_ready}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      chk("rs2_no_ori", {31'd0, inst_valid}, 32'd0);
    end

    // Randomized traffic, checked by the scoreboard.
    for (int unsigned i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      inst_ready = ($urandom_range(0, 3) != 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_li     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       req_opcode = 6'($urandom_range(0, 3));
        default: req_opcode = 6'($urandom);
      endcase
      req_func = 6'($urandom);
      req_rd   = 5'($urandom);
      req_rs1  = 5'($urandom);
      req_rs2  = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       req_imm = 32'($signed(16'($urandom)));
        1:       req_imm = $urandom & 32'hFFFF0000;
        default: req_imm = $urandom;
      endcase
    end
    req_valid  = 1'b0;
    inst_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) cyc();
    chk("final_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
